sprdma: RTL and testbench
=========================

SPRDMA -- requirements
Module: sprdma

Interface
REQ-001 SHALL provide parameter DMA_REG_ADDR, 16'h4014, bus address whose write triggers a transfer.
REQ-002 SHALL provide parameter OAM_DATA_ADDR, 16'h2004, PPU OAM data port address used as the write target.
REQ-003 SHALL provide clk_in  input  1  system clock; all state changes on its rising edge.
REQ-004 SHALL provide nrst_in  input  1  reset, asynchronous, active-low.
REQ-005 SHALL provide cpumc_a_in  input  16  snooped muxed CPU memory-bus address.
REQ-006 SHALL provide cpumc_din_in  input  8  snooped bus write data.
REQ-007 SHALL provide cpumc_dout_in  input  8  bus read data returned by memory (OR of all slaves).
REQ-008 SHALL provide cpu_r_nw_in  input  1  snooped bus R/!W.
REQ-009 SHALL provide active_out  output  1  DMA owns the bus; the CPU is stalled (ready low).
REQ-010 SHALL provide cpumc_a_out  output  16  DMA bus address.
REQ-011 SHALL provide cpumc_d_out  output  8  DMA bus write data.
REQ-012 SHALL provide cpumc_r_nw_out  output  1  DMA bus R/!W.
REQ-013 SHALL provide done_out  output  1  one-cycle pulse on transfer completion.

Function
REQ-014 SHALL implement states IDLE, START, READ, LATCH, WRITE; IDLE is the reset state.
REQ-015 In IDLE, a cycle with cpu_r_nw_in=0 and cpumc_a_in==DMA_REG_ADDR (exact match, no mirrors) SHALL capture page<=cpumc_din_in, clear idx to 0, and enter START next cycle.
REQ-016 A cycle with cpu_r_nw_in=1 at DMA_REG_ADDR SHALL NOT trigger.
REQ-017 Trigger detection SHALL be ignored outside IDLE.
REQ-018 START SHALL last exactly 1 cycle and drive cpumc_a_out=0, cpumc_r_nw_out=1, cpumc_d_out=0; next state READ.
REQ-019 READ SHALL drive cpumc_a_out={page,idx}, cpumc_r_nw_out=1; next state LATCH.
REQ-020 LATCH SHALL hold the READ address and r_nw=1, and capture data<=cpumc_dout_in at the end of the cycle (synchronous-read slaves); next state WRITE.
REQ-021 WRITE SHALL drive cpumc_a_out=OAM_DATA_ADDR, cpumc_r_nw_out=0, cpumc_d_out=data.
REQ-022 From WRITE with idx!=8'hFF, the block SHALL increment idx and return to READ.
REQ-023 From WRITE with idx==8'hFF, the block SHALL go to IDLE with done_out=1 for that first IDLE cycle only.
REQ-024 idx SHALL be 8 bits; the source address SHALL never carry into page (page FF reads FF00-FFFF).
REQ-025 active_out SHALL be a registered output, high in every START/READ/LATCH/WRITE cycle and low in IDLE.
REQ-026 A transfer SHALL occupy exactly 769 active cycles (1 + 256*3).
REQ-027 In IDLE, outputs SHALL be cpumc_a_out=0, cpumc_d_out=0, cpumc_r_nw_out=1.
REQ-028 cpumc_d_out SHALL be 0 in every non-WRITE state.
REQ-029 A new trigger SHALL be accepted in the cycle done_out is high; done_out and the capture then coincide.

Reset
REQ-030 nrst_in=0 SHALL immediately, without a clock edge, force state=IDLE, page=0, idx=0, data=0, active_out=0, done_out=0, cpumc_a_out=0, cpumc_d_out=0, cpumc_r_nw_out=1.
REQ-031 Reset asserted mid-transfer SHALL abort with no done_out pulse; no further OAM writes SHALL occur after release.
REQ-032 A trigger coinciding with reset SHALL be discarded.
REQ-033 After release, the first trigger SHALL be accepted no earlier than the first rising edge with nrst_in=1.

Verification
REQ-034 Bench: write 8'h02 to 16'h4014 -> active_out rises next cycle; reads 0200..02FF each followed two cycles later by a write to 2004 of the model RAM byte; 769 active cycles; done_out pulses once.
REQ-035 Bench: read (r_nw=1) of 4014, then write to 4015 -> active_out stays 0 throughout.
REQ-036 Bench: page 8'hFF -> last read address FFFF; next address is 2004 write, never 0000.
REQ-037 Bench: nrst_in low during LATCH of idx 8'h40 -> outputs to reset values asynchronously; no done_out; no further 2004 writes.
REQ-038 Bench: retrigger with page 8'h03 in the done_out cycle -> second transfer starts next cycle, sourcing 0300..03FF.

Source files
------------

// File: rtl/sprdma.sv
// Sprite DMA engine: copies one 256-byte page to the PPU OAM data port.
// Snoops CPU writes for the trigger and owns the bus while copying.
module sprdma #(
  parameter logic [15:0] DMA_REG_ADDR  = 16'h4014,
  parameter logic [15:0] OAM_DATA_ADDR = 16'h2004
) (
  input  logic        clk_in,
  input  logic        nrst_in,
  input  logic [15:0] cpumc_a_in,
  input  logic [7:0]  cpumc_din_in,
  input  logic [7:0]  cpumc_dout_in,
  input  logic        cpu_r_nw_in,
  output logic        active_out,
  output logic [15:0] cpumc_a_out,
  output logic [7:0]  cpumc_d_out,
  output logic        cpumc_r_nw_out,
  output logic        done_out
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    READ  = 3'd2,
    LATCH = 3'd3,
    WRITE = 3'd4
  } state_t;

  state_t      state_q, state_d;
  logic [7:0]  page_q, page_d;
  logic [7:0]  idx_q, idx_d;
  logic [7:0]  data_q, data_d;
  logic        active_q, active_d;
  logic        done_q, done_d;
  logic        trig;

  assign trig = !cpu_r_nw_in &&
                (cpumc_a_in == DMA_REG_ADDR);

  // Next-state, capture and completion logic.
  always_comb begin
    state_d = state_q;
    page_d  = page_q;
    idx_d   = idx_q;
    data_d  = data_q;
    done_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (trig) begin
          page_d  = cpumc_din_in;
          idx_d   = 8'h00;
          state_d = START;
        end
      end
      START: state_d = READ;
      READ:  state_d = LATCH;
      LATCH: begin
        data_d  = cpumc_dout_in;
        state_d = WRITE;
      end
      WRITE: begin
        if (idx_q == 8'hFF) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end else begin
          idx_d   = idx_q + 8'h01;
          state_d = READ;
        end
      end
      default: state_d = IDLE;
    endcase
    active_d = (state_d != IDLE);
  end

  // Bus drive decoded from the current state.
  always_comb begin
    cpumc_a_out    = 16'h0000;
    cpumc_d_out    = 8'h00;
    cpumc_r_nw_out = 1'b1;
    unique case (state_q)
      READ,
      LATCH: cpumc_a_out = {page_q, idx_q};
      WRITE: begin
        cpumc_a_out    = OAM_DATA_ADDR;
        cpumc_r_nw_out = 1'b0;
        cpumc_d_out    = data_q;
      end
      default: ;
    endcase
  end

  // State registers with asynchronous clear.
  always_ff @(posedge clk_in or negedge nrst_in) begin
    if (!nrst_in) begin
      state_q  <= IDLE;
      page_q   <= 8'h00;
      idx_q    <= 8'h00;
      data_q   <= 8'h00;
      active_q <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      page_q   <= page_d;
      idx_q    <= idx_d;
      data_q   <= data_d;
      active_q <= active_d;
      done_q   <= done_d;
    end
  end

  assign active_out = active_q;
  assign done_out   = done_q;

endmodule

// File: tb/tb_sprdma.sv
// Bench for sprdma: random RAM image, synchronous-read slave model,
// expected bus trace derived from the transfer rules.
module tb_sprdma;

  logic        clk = 1'b0;
  logic        nrst = 1'b1;
  logic [15:0] a_in = 16'h0000;
  logic [7:0]  din = 8'h00;
  logic [7:0]  dout;
  logic        rnw_in = 1'b1;
  logic        active;
  logic [15:0] a_out;
  logic [7:0]  d_out;
  logic        rnw_out;
  logic        done;

  int checks = 0;
  int failures = 0;

  logic [7:0]  ram [0:65535];
  logic [15:0] rd_q = 16'h0000;
  logic [24:0] lg [0:1023];
  int          n;

  sprdma dut (
    .clk_in        (clk),
    .nrst_in       (nrst),
    .cpumc_a_in    (a_in),
    .cpumc_din_in  (din),
    .cpumc_dout_in (dout),
    .cpu_r_nw_in   (rnw_in),
    .active_out    (active),
    .cpumc_a_out   (a_out),
    .cpumc_d_out   (d_out),
    .cpumc_r_nw_out(rnw_out),
    .done_out      (done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) rd_q <= a_out;
  assign dout = ram[rd_q];

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h",
             tag, obs, exp);
    end
  endtask

  task automatic idle_in();
    a_in = 16'h0000;
    din = 8'h00;
    rnw_in = 1'b1;
  endtask

  task automatic drive_trig(input logic [7:0] p);
    a_in = 16'h4014;
    din = p;
    rnw_in = 1'b0;
  endtask

  task automatic trig(input logic [7:0] p);
    @(negedge clk);
    chk("pre_idle", {31'd0, active}, 32'd0);
    drive_trig(p);
  endtask

  task automatic do_xfer(input logic [7:0] page,
                         input bit retrig,
                         input logic [7:0] rpage);
    bit got;
    int j;
    int ph;
    logic [15:0] src;
    logic [24:0] e;
    n = 0;
    got = 0;
    for (int c = 0; c < 900 && !got; c++) begin
      @(negedge clk);
      if (c == 0)
        chk("start_active", {31'd0, active}, 32'd1);
      if (active && n < 1024) begin
        lg[n] = {a_out, rnw_out, d_out};
        n++;
      end
      idle_in();
      if (n == 100 && active)
        drive_trig(8'h55);
      if (done) begin
        got = 1;
        chk("done_idle", {active, a_out, rnw_out, d_out},
            {1'b0, 16'h0000, 1'b1, 8'h00});
        if (retrig) drive_trig(rpage);
      end
    end
    chk("done_seen", {31'd0, got}, 32'd1);
    chk("active_len", n, 769);
    for (int k = 0; k < n; k++) begin
      if (k == 0) begin
        e = {16'h0000, 1'b1, 8'h00};
      end else begin
        j = (k - 1) / 3;
        ph = (k - 1) % 3;
        src = {page, j[7:0]};
        if (ph < 2) e = {src, 1'b1, 8'h00};
        else e = {16'h2004, 1'b0, ram[src]};
      end
      chk($sformatf("trace[%0d]", k), {7'd0, lg[k]}, {7'd0, e});
    end
  endtask

  initial begin
    int cnt;
    int dn;
    logic [7:0] pg;
    for (int i = 0; i < 65536; i++) ram[i] = 8'($urandom);

    #3 nrst = 1'b0;
    #1;
    chk("rst_async", {active, a_out, rnw_out, d_out, done},
        {1'b0, 16'h0000, 1'b1, 8'h00, 1'b0});
    repeat (2) @(negedge clk);
    nrst = 1'b1;
    @(negedge clk);
    chk("rst_idle", {active, a_out, rnw_out, d_out, done},
        {1'b0, 16'h0000, 1'b1, 8'h00, 1'b0});

    a_in = 16'h4014; din = 8'h02; rnw_in = 1'b1;
    @(negedge clk);
    a_in = 16'h4015; din = 8'h02; rnw_in = 1'b0;
    @(negedge clk);
    idle_in();
    cnt = 0;
    for (int c = 0; c < 12; c++) begin
      if (active) cnt++;
      @(negedge clk);
    end
    chk("no_trig_cnt", cnt, 0);

    trig(8'h02);
    do_xfer(8'h02, 0, 8'h00);
    @(negedge clk);
    chk("done_once", {30'd0, done, active}, 32'd0);

    pg = 8'($urandom_range(4, 254));
    trig(pg);
    do_xfer(pg, 1, 8'h03);
    do_xfer(8'h03, 0, 8'h00);
    @(negedge clk);
    chk("retrig_end", {30'd0, done, active}, 32'd0);

    trig(8'hFF);
    do_xfer(8'hFF, 0, 8'h00);
    chk("ff_last_rd", {16'd0, lg[767][24:9]}, 32'h0000FFFF);
    chk("ff_after", {16'd0, lg[768][24:9]}, 32'h00002004);

    trig(8'h12);
    n = 0;
    for (int c = 0; c < 900 && n < 195; c++) begin
      @(negedge clk);
      if (active) n++;
      idle_in();
    end
    chk("latch_reached", n, 195);
    chk("latch_addr", {15'd0, a_out, rnw_out}, {15'd0, 16'h1240, 1'b1});
    #1 nrst = 1'b0;
    drive_trig(8'h77);
    #1;
    chk("rst_mid", {active, a_out, rnw_out, d_out, done},
        {1'b0, 16'h0000, 1'b1, 8'h00, 1'b0});
    repeat (3) @(negedge clk);
    idle_in();
    #1 nrst = 1'b1;
    cnt = 0;
    dn = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (active || !rnw_out || a_out == 16'h2004) cnt++;
      if (done) dn++;
    end
    chk("post_rst_quiet", cnt, 0);
    chk("post_rst_done", dn, 0);

    trig(8'hA5);
    do_xfer(8'hA5, 0, 8'h00);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
